mmio_uart_fifo: RTL



---
 rtl/mmio_uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/mmio_uart_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared register map, status bit positions and FSM encodings for the MMIO UART/GPIO peripheral.
package mmio_uart_pkg;

    localparam int unsigned OFS_W = 5;

    localparam logic [OFS_W-1:0] OFS_DATA   = 5'd0;
    localparam logic [OFS_W-1:0] OFS_STATUS = 5'd1;
    localparam logic [OFS_W-1:0] OFS_RXCNT  = 5'd2;
    localparam logic [OFS_W-1:0] OFS_TXCNT  = 5'd3;
    localparam logic [OFS_W-1:0] OFS_GPO    = 5'd8;
    localparam logic [OFS_W-1:0] OFS_GPI    = 5'd16;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_TX_FULL     = 1;
    localparam int unsigned ST_RX_OVF      = 2;
    localparam int unsigned ST_TX_OVF      = 3;
    localparam int unsigned ST_TX_IDLE     = 4;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo
    import mmio_uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage array: written on accepted pushes, not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally at power-of-2 depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_uart_fifo.sv
// MMIO peripheral: GPIO bank plus UART byte engine with RX/TX FIFOs, status and occupancy counts.
module mmio_uart_fifo
    import mmio_uart_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'hffe0,
    parameter int unsigned RX_DEPTH   = 8,
    parameter int unsigned TX_DEPTH   = 8,
    parameter int unsigned GPIO_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               addr,
    input  logic [7:0]                data_in,
    input  logic                      write_en,
    input  logic                      read_en,
    output logic [7:0]                data_out,
    output logic                      hit,
    input  logic [8*GPIO_BYTES-1:0]   io_inputs,
    output logic [8*GPIO_BYTES-1:0]   io_outputs,
    output logic [7:0]                uart_in,
    output logic                      uart_write_en,
    input  logic                      uart_txbuf_empty,
    input  logic [7:0]                uart_out,
    input  logic                      uart_data_avail,
    output logic                      uart_clear_avail
);

    localparam int unsigned GPIO_W = 8 * GPIO_BYTES;
    localparam int unsigned RXCW   = $clog2(RX_DEPTH) + 1;
    localparam int unsigned TXCW   = $clog2(TX_DEPTH) + 1;

    logic              write_en_q, read_en_q;
    logic              wr_go, rd_go, in_win;
    logic [OFS_W-1:0]  ofs;

    tx_state_e         tx_state_q, tx_state_d;
    rx_state_e         rx_state_q, rx_state_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic [GPIO_W-1:0] io_outputs_q, io_outputs_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              hit_q, hit_d;
    logic [7:0]        uart_in_q, uart_in_d;
    logic              uart_write_en_q, uart_write_en_d;
    logic              uart_clear_avail_q, uart_clear_avail_d;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]        rx_dout, tx_dout;
    logic [RXCW-1:0]   rx_count;
    logic [TXCW-1:0]   tx_count;
    logic [7:0]        status;
    logic [7:0]        rd_data;

    assign in_win  = (addr[15:5] == BASE[15:5]);
    assign ofs     = addr[4:0];
    assign wr_go   = write_en & ~write_en_q;
    assign rd_go   = read_en & ~read_en_q;

    assign rx_pop  = rd_go & in_win & (ofs == OFS_DATA);
    assign rx_push = (rx_state_q == RX_IDLE) & uart_data_avail;
    assign tx_push = wr_go & in_win & (ofs == OFS_DATA);
    assign tx_pop  = (tx_state_q == TX_LOAD);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (uart_out),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (data_in),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Assemble the STATUS register view.
    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = ~rx_empty;
        status[ST_TX_FULL]     = tx_full;
        status[ST_RX_OVF]      = rx_ovf_q;
        status[ST_TX_OVF]      = tx_ovf_q;
        status[ST_TX_IDLE]     = tx_empty & (tx_state_q == TX_IDLE);
    end

    // Read mux over the register map; DATA shows the pre-pop RX head.
    always_comb begin
        rd_data = '0;
        case (ofs)
            OFS_DATA:   rd_data = rx_empty ? 8'h00 : rx_dout;
            OFS_STATUS: rd_data = status;
            OFS_RXCNT:  rd_data = 8'(rx_count);
            OFS_TXCNT:  rd_data = 8'(tx_count);
            default:    ;
        endcase
        for (int n = 0; n < int'(GPIO_BYTES); n++) begin
            if (ofs == (OFS_GPO + 5'(n))) rd_data = io_outputs_q[8*n +: 8];
            if (ofs == (OFS_GPI + 5'(n))) rd_data = io_inputs[8*n +: 8];
        end
    end

    // Next-state for both FSMs, sticky flags, GPIO latch and registered outputs.
    always_comb begin
        tx_state_d         = tx_state_q;
        rx_state_d         = rx_state_q;
        rx_ovf_d           = rx_ovf_q;
        tx_ovf_d           = tx_ovf_q;
        io_outputs_d       = io_outputs_q;
        uart_in_d          = uart_in_q;
        uart_write_en_d    = 1'b0;
        uart_clear_avail_d = 1'b0;
        hit_d              = in_win;
        data_out_d         = in_win ? rd_data : 8'h00;

        case (tx_state_q)
            TX_IDLE: if (~tx_empty & uart_txbuf_empty) tx_state_d = TX_LOAD;
            TX_LOAD: tx_state_d = TX_WAIT;
            TX_WAIT: if (~uart_txbuf_empty) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase

        case (rx_state_q)
            RX_IDLE: if (uart_data_avail) rx_state_d = RX_ACK;
            RX_ACK:  if (~uart_data_avail) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase

        // Clear-on-write first so a same-cycle overflow still wins.
        if (wr_go & in_win & (ofs == OFS_STATUS)) begin
            if (data_in[ST_RX_OVF]) rx_ovf_d = 1'b0;
            if (data_in[ST_TX_OVF]) tx_ovf_d = 1'b0;
        end
        if (rx_push & rx_full & ~rx_pop) rx_ovf_d = 1'b1;
        if (tx_push & tx_full & ~tx_pop) tx_ovf_d = 1'b1;

        for (int n = 0; n < int'(GPIO_BYTES); n++) begin
            if (wr_go & in_win & (ofs == (OFS_GPO + 5'(n)))) begin
                io_outputs_d[8*n +: 8] = data_in;
            end
        end

        // Outputs are registered copies of the upcoming state decode; head is stable from IDLE into LOAD.
        if (tx_state_d == TX_LOAD) begin
            uart_write_en_d = 1'b1;
            uart_in_d       = tx_dout;
        end
        uart_clear_avail_d = (rx_state_d == RX_ACK);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_en_q         <= 1'b0;
            read_en_q          <= 1'b0;
            tx_state_q         <= TX_IDLE;
            rx_state_q         <= RX_IDLE;
            rx_ovf_q           <= 1'b0;
            tx_ovf_q           <= 1'b0;
            io_outputs_q       <= '0;
            data_out_q         <= '0;
            hit_q              <= 1'b0;
            uart_in_q          <= '0;
            uart_write_en_q    <= 1'b0;
            uart_clear_avail_q <= 1'b0;
        end else begin
            write_en_q         <= write_en;
            read_en_q          <= read_en;
            tx_state_q         <= tx_state_d;
            rx_state_q         <= rx_state_d;
            rx_ovf_q           <= rx_ovf_d;
            tx_ovf_q           <= tx_ovf_d;
            io_outputs_q       <= io_outputs_d;
            data_out_q         <= data_out_d;
            hit_q              <= hit_d;
            uart_in_q          <= uart_in_d;
            uart_write_en_q    <= uart_write_en_d;
            uart_clear_avail_q <= uart_clear_avail_d;
        end
    end

    assign data_out         = data_out_q;
    assign hit              = hit_q;
    assign io_outputs       = io_outputs_q;
    assign uart_in          = uart_in_q;
    assign uart_write_en    = uart_write_en_q;
    assign uart_clear_avail = uart_clear_avail_q;

endmodule
